// File: rtl/registro_digitos_bcd.sv
// =============================================================================
// registro_digitos_bcd
// -----------------------------------------------------------------------------
// Keypad digit register for the timer preset path. It sits after the keypad
// priority encoder and:
//   - debounces the "any key" flag together with the encoded BCD digit,
//   - registers exactly one digit per physical key press,
//   - shifts accepted digits into a packed BCD buffer (MM:SS style entry),
//     the buffer being the preset value consumed by the countdown stage.
//
// Parameters
//   NUM_DIGITOS  number of BCD digits held in the buffer (>= 1)
//   DEBOUNCE     consecutive identical samples needed to accept a press or
//                a release (>= 2)
//
// Ports
//   clk           in   1          system clock, all state changes on rising edge
//   resetn        in   1          synchronous active-low reset
//   tecla_valida  in   1          1 = some key 0-9 pressed
//   bcd           in   4          encoded digit, meaningful when tecla_valida=1
//   limpar        in   1          synchronous clear of the buffer
//   travar        in   1          1 = timer running, key entry locked
//   digitos       out  4*NUM_DIGITOS  packed BCD buffer, newest digit in [3:0]
//   qtd_digitos   out  clog2(NUM_DIGITOS+1)  digits entered since clear,
//                                saturating at NUM_DIGITOS
//   novo_digito   out  1          one-cycle pulse on the cycle a digit shifts in
//   overflow      out  1          sticky entry-overflow flag
//
// Build option
//   DIGIT_LIMIT_EN  when defined, a full buffer refuses further digits and
//                   raises the sticky overflow flag instead of dropping the
//                   oldest digit. When undefined, overflow is tied to 0.
// =============================================================================
module registro_digitos_bcd #(
   parameter int NUM_DIGITOS = 4,
   parameter int DEBOUNCE    = 4
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic                               tecla_valida,
   input  logic [3:0]                         bcd,
   input  logic                               limpar,
   input  logic                               travar,
   output logic [4*NUM_DIGITOS-1:0]           digitos,
   output logic [$clog2(NUM_DIGITOS+1)-1:0]   qtd_digitos,
   output logic                               novo_digito,
   output logic                               overflow
);

   localparam int QTD_W = $clog2(NUM_DIGITOS + 1);
   localparam int CNT_W = $clog2(DEBOUNCE + 1);

   // The counter holds the number of samples already seen; the move happens
   // on the edge that would take it to DEBOUNCE.
   localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0] CNT_UM     = CNT_W'(1);
   localparam logic [QTD_W-1:0] QTD_MAX    = QTD_W'(NUM_DIGITOS);

   typedef enum logic [1:0] {
      OCIOSO,       // no key seen
      FILTRANDO,    // key seen, waiting for DEBOUNCE stable samples
      PRESSIONADO,  // press consumed, waiting for the key to go away
      SOLTANDO      // key seen released, waiting for DEBOUNCE low samples
   } estado_t;

   // --------------------------------------------------------------------------
   // State and datapath registers
   // --------------------------------------------------------------------------
   estado_t                  r_estado;
   estado_t                  w_estado_next;
   logic [CNT_W-1:0]         r_cnt;
   logic [CNT_W-1:0]         w_cnt_next;
   logic [3:0]               r_amostra;
   logic [3:0]               w_amostra_next;
   logic                     w_fim_filtro;

   logic [4*NUM_DIGITOS-1:0] r_digitos;
   logic [4*NUM_DIGITOS-1:0] w_digitos_desloc;
   logic [QTD_W-1:0]         r_qtd;
   logic                     r_novo;

   logic                     w_digito_ok;
   logic                     w_cheio;
   logic                     w_aceita;

   // --------------------------------------------------------------------------
   // FSM state register
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_estado  <= OCIOSO;
         r_cnt     <= '0;
         r_amostra <= '0;
      end else begin
         r_estado  <= w_estado_next;
         r_cnt     <= w_cnt_next;
         r_amostra <= w_amostra_next;
      end
   end

   // --------------------------------------------------------------------------
   // FSM next state
   //
   // A key that is already down while entry is locked (or while the buffer is
   // being cleared) is treated as consumed: the FSM parks in PRESSIONADO and
   // only a genuine release followed by a new press can enter a digit. This
   // keeps a held key from slipping in the moment travar or limpar drops.
   // --------------------------------------------------------------------------
   always_comb begin
      w_estado_next  = r_estado;
      w_cnt_next     = r_cnt;
      w_amostra_next = r_amostra;
      w_fim_filtro   = 1'b0;

      if (limpar) begin
         // Any partial press is discarded; a held key must be released first.
         w_estado_next = tecla_valida ? PRESSIONADO : OCIOSO;
         w_cnt_next    = '0;
      end else begin
         case (r_estado)
            OCIOSO: begin
               if (tecla_valida) begin
                  if (travar) begin
                     w_estado_next = PRESSIONADO;
                  end else begin
                     // This edge is the first of the DEBOUNCE samples.
                     w_estado_next  = FILTRANDO;
                     w_amostra_next = bcd;
                     w_cnt_next     = CNT_UM;
                  end
               end
            end

            FILTRANDO: begin
               if (!tecla_valida || (bcd != r_amostra) || travar) begin
                  w_estado_next = OCIOSO;
                  w_cnt_next    = '0;
               end else if (r_cnt == CNT_ULTIMO) begin
                  w_estado_next = PRESSIONADO;
                  w_cnt_next    = '0;
                  w_fim_filtro  = 1'b1;
               end else begin
                  w_cnt_next = r_cnt + CNT_UM;
               end
            end

            PRESSIONADO: begin
               // Digit changes while held are ignored on purpose.
               if (!tecla_valida) begin
                  w_estado_next = SOLTANDO;
                  w_cnt_next    = CNT_UM;
               end
            end

            SOLTANDO: begin
               // A bounce back to 1 returns to PRESSIONADO, never to filtering,
               // so a noisy release cannot produce a second digit.
               if (tecla_valida) begin
                  w_estado_next = PRESSIONADO;
                  w_cnt_next    = '0;
               end else if (r_cnt == CNT_ULTIMO) begin
                  w_estado_next = OCIOSO;
                  w_cnt_next    = '0;
               end else begin
                  w_cnt_next = r_cnt + CNT_UM;
               end
            end

            default: begin
               w_estado_next = OCIOSO;
               w_cnt_next    = '0;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Shifted buffer: each digit slot takes the one below it, slot 0 takes the
   // newly accepted sample.
   // --------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_DIGITOS; gi++) begin : g_desloc
         if (gi == 0) begin : g_novo
            assign w_digitos_desloc[3:0] = r_amostra;
         end else begin : g_antigo
            assign w_digitos_desloc[4*gi+3 -: 4] = r_digitos[4*gi-1 -: 4];
         end
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Accept decision. w_fim_filtro is already suppressed by limpar, and can
   // only fire with travar low, so those priorities come for free here.
   // --------------------------------------------------------------------------
   assign w_digito_ok = w_fim_filtro && (r_amostra <= 4'd9);
   assign w_cheio     = (r_qtd == QTD_MAX);

`ifdef DIGIT_LIMIT_EN
   logic w_excede;
   logic r_overflow;

   assign w_aceita = w_digito_ok && !w_cheio;
   assign w_excede = w_digito_ok && w_cheio;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_overflow <= 1'b0;
      end else if (limpar) begin
         r_overflow <= 1'b0;
      end else if (w_excede) begin
         r_overflow <= 1'b1;
      end
   end

   assign overflow = r_overflow;
`else
   // Full buffer: the oldest digit simply falls off the top.
   assign w_aceita = w_digito_ok;
   assign overflow = 1'b0;
`endif

   // --------------------------------------------------------------------------
   // Buffer, digit count and pulse
   // --------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_digitos <= '0;
         r_qtd     <= '0;
         r_novo    <= 1'b0;
      end else if (limpar) begin
         r_digitos <= '0;
         r_qtd     <= '0;
         r_novo    <= 1'b0;
      end else begin
         r_novo <= w_aceita;
         if (w_aceita) begin
            r_digitos <= w_digitos_desloc;
            if (!w_cheio) begin
               r_qtd <= r_qtd + QTD_W'(1);
            end
         end
      end
   end

   assign digitos     = r_digitos;
   assign qtd_digitos = r_qtd;
   assign novo_digito = r_novo;

endmodule
